// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the execute-stage divider sequencer.
//   - div_state_e      : FSM state encoding (IDLE/BYZERO/BUSY/DONE)
//   - DIV_WIDTH        : operand width
//   - DIV_RESULT_WIDTH : width of the {remainder, quotient} result
//   - STALL_*          : stall request encoding seen by the pipeline controller
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH        = 32;
  localparam int DIV_RESULT_WIDTH = 2 * DIV_WIDTH;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_BUSY   = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_e;

  localparam logic STALL_NO  = 1'b0;
  localparam logic STALL_YES = 1'b1;

endpackage

// File: rtl/ex_div_seq_if.sv
// ---------------------------------------------------------------------------
// ex_div_seq_if
// Request/response bundle between the execute stage (master) and the
// divider sequencer (slave).
//   start_i    : division request, held until ready_o
//   annul_i    : flush of the request / operation in flight
//   signed_i   : 1 = DIV, 0 = DIVU
//   opdata1_i  : dividend
//   opdata2_i  : divisor
//   result_o   : {remainder, quotient}, non-zero only while ready_o=1
//   ready_o    : result valid
//   stallreq_o : pipeline stall request
// ---------------------------------------------------------------------------
interface ex_div_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic               start_i;
  logic               annul_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  // Execute stage side.
  modport master (
    output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  // Divider side.
  modport slave (
    input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One radix-2 restoring division step (purely combinational).
//   partial_i : {partial remainder, next dividend bit}, WIDTH+1 bits
//   divisor_i : divisor magnitude
//   rem_o     : new partial remainder
//   qbit_o    : quotient bit (1 = trial subtraction had no borrow)
// ---------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   sel;
  logic             sel_msb_unused;

  // One extra bit above the operands carries the borrow out.
  assign diff   = {1'b0, partial_i} - {2'b00, divisor_i};
  assign qbit_o = ~diff[WIDTH+1];

  // The partial remainder is always below the divisor, so the kept value
  // fits in WIDTH bits and the top bit of sel is always zero.
  assign sel            = qbit_o ? diff[WIDTH:0] : partial_i;
  assign rem_o          = sel[WIDTH-1:0];
  assign sel_msb_unused = sel[WIDTH];

endmodule

// File: rtl/ex_div_seq.sv
// ---------------------------------------------------------------------------
// ex_div_seq
// Multi-cycle restoring divider for the execute stage. Accepts one DIV/DIVU
// at a time, produces one quotient bit per cycle, then spends one final
// BUSY cycle on sign correction before presenting the result in DONE.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : ex_div_seq_if.slave (start/annul/signed/operands in,
//          result/ready/stallreq out)
//
// Build option:
//   DIV_SIGNED_EN : when defined, signed_i=1 divides signed operands
//                   (quotient truncates toward zero, remainder follows the
//                   dividend's sign). When undefined, all divisions are
//                   unsigned and signed_i is ignored.
// ---------------------------------------------------------------------------
module ex_div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  ex_div_seq_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  // Counter value of the sign-correction cycle that follows the last step.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]  ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // dvd_q holds the dividend; quotient bits shift in from the bottom as the
  // dividend bits shift out of the top, so it ends up holding the quotient.
  logic [WIDTH-1:0]    dvd_q, dvd_d;
  logic [WIDTH-1:0]    dvs_q, dvs_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic                ready_q, ready_d;

  logic [WIDTH-1:0]    mag1, mag2;
  logic [WIDTH-1:0]    quot_fix, rem_fix;
  logic [WIDTH-1:0]    step_rem;
  logic                step_qbit;
  logic                leave;

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_i ({rem_q, dvd_q[WIDTH-1]}),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

`ifdef DIV_SIGNED_EN
  logic sign1_q, sign1_d;
  logic sign2_q, sign2_d;
  logic neg1, neg2;

  assign neg1 = bus.signed_i & bus.opdata1_i[WIDTH-1];
  assign neg2 = bus.signed_i & bus.opdata2_i[WIDTH-1];
  assign mag1 = neg1 ? (~bus.opdata1_i + ONE_W) : bus.opdata1_i;
  assign mag2 = neg2 ? (~bus.opdata2_i + ONE_W) : bus.opdata2_i;

  // Most-negative / -1 negates 0x80..0 back to itself: wraps silently.
  assign quot_fix = (sign1_q ^ sign2_q) ? (~dvd_q + ONE_W) : dvd_q;
  assign rem_fix  = sign1_q ? (~rem_q + ONE_W) : rem_q;
`else
  logic signed_unused;

  assign signed_unused = bus.signed_i;
  assign mag1          = bus.opdata1_i;
  assign mag2          = bus.opdata2_i;
  assign quot_fix      = dvd_q;
  assign rem_fix       = rem_q;
`endif

  // Abort / release condition shared by BYZERO, BUSY and DONE.
  assign leave = bus.annul_i | ~bus.start_i;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_SIGNED_EN
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
`endif
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        // annul_i wins over start_i.
        if (bus.start_i && !bus.annul_i) begin
          state_d = (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_BUSY;
        end
      end
      DIV_BYZERO: state_d = leave ? DIV_IDLE : DIV_DONE;
      DIV_BUSY: begin
        if (leave) begin
          state_d = DIV_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (leave) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // ---------------- output / datapath logic ----------------
  always_comb begin
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    result_d = '0;
    ready_d  = (state_d == DIV_DONE);
`ifdef DIV_SIGNED_EN
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
`endif
    case (state_q)
      DIV_IDLE: begin
        if (state_d == DIV_BUSY) begin
          dvd_d   = mag1;
          dvs_d   = mag2;
          rem_d   = '0;
          cnt_d   = '0;
`ifdef DIV_SIGNED_EN
          sign1_d = neg1;
          sign2_d = neg2;
`endif
        end
      end
      DIV_BUSY: begin
        if (cnt_q != CNT_LAST) begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
          cnt_d = cnt_q + CNT_ONE;
        end
        if (state_d == DIV_DONE) begin
          result_d = {rem_fix, quot_fix};
        end
      end
      DIV_DONE: begin
        if (state_d == DIV_DONE) begin
          result_d = result_q;
        end
      end
      default: ;  // BYZERO -> DONE loads a zero result
    endcase
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = (bus.start_i && !ready_q) ? STALL_YES : STALL_NO;

endmodule

// File: tb/tb_ex_div_seq.sv
module tb_ex_div_seq;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;
  localparam int DIV_LAT  = W + 2;  // edges from raising start_i to ready_o
  localparam int ZERO_LAT = 2;
  localparam int BOUND    = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_div_seq_if #(.WIDTH(W)) bus ();

  ex_div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [0:9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference division using the simulator's own 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = {32'd0, a};
    sb = {32'd0, b};
`ifdef DIV_SIGNED_EN
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end
`endif
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready_o !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_txn(input string name);
    logic [63:0] exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'd0;
    if (bus.ready_o === 1'b1) begin
      check({name, " result"}, bus.result_o, exp);
      check({name, " stall at ready"}, 64'(bus.stallreq_o), 64'd0);
      tick();
      check({name, " done hold"}, bus.result_o, exp);
    end
    bus.start_i = 1'b0;
    tick();
    check({name, " ready clear"}, 64'(bus.ready_o), 64'd0);
    check({name, " result clear"}, bus.result_o, 64'd0);
  endtask

  task automatic run_div(input vec_t v);
    int  n;
    bit  stall_ok, zero_ok;
    bus.opdata1_i = v.a;
    bus.opdata2_i = v.b;
    bus.signed_i  = v.s;
    bus.start_i   = 1'b1;
    sb_q.push_back(v.exp);
    #1;
    n = 0;
    stall_ok = 1'b1;
    zero_ok  = 1'b1;
    while (bus.ready_o !== 1'b1 && n < BOUND) begin
      if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
      if (bus.result_o !== 64'd0) zero_ok = 1'b0;
      tick();
      n++;
      // Operands must only matter at the accept edge.
      if (n == 1) begin
        bus.opdata1_i = ~v.a;
        bus.opdata2_i = ~v.b;
        bus.signed_i  = ~v.s;
      end
    end
    $display("txn %s a=%h b=%h s=%0d result=%h lat=%0d", v.name, v.a, v.b, v.s, bus.result_o, n);
    check({v.name, " latency"}, 64'(n), 64'(v.lat));
    check({v.name, " stall before ready"}, 64'(stall_ok), 64'd1);
    check({v.name, " result zero before ready"}, 64'(zero_ok), 64'd1);
    finish_txn(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic        rs;

    bus.start_i   = 1'b0;
    bus.annul_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;

    vecs[0] = '{"u100/7",   32'd100,        32'd7,          1'b0, {32'd2, 32'd14},            DIV_LAT};
    vecs[1] = '{"divzero",  32'h12345678,   32'd0,          1'b0, 64'd0,                      ZERO_LAT};
`ifdef DIV_SIGNED_EN
    vecs[2] = '{"s-7/2",    32'hFFFFFFF9,   32'h2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, DIV_LAT};
    vecs[3] = '{"sovf",     32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h0, 32'h80000000},      DIV_LAT};
    vecs[5] = '{"s7/-2",    32'd7,          32'hFFFFFFFE,   1'b1, {32'd1, 32'hFFFFFFFD},      DIV_LAT};
`else
    vecs[2] = '{"s-7/2",    32'hFFFFFFF9,   32'h2,          1'b1, {32'd1, 32'h7FFFFFFC},      DIV_LAT};
    vecs[3] = '{"sovf",     32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h80000000, 32'h0},      DIV_LAT};
    vecs[5] = '{"s7/-2",    32'd7,          32'hFFFFFFFE,   1'b1, {32'd7, 32'd0},             DIV_LAT};
`endif
    vecs[4] = '{"uovf",     32'h80000000,   32'hFFFFFFFF,   1'b0, {32'h80000000, 32'h0},      DIV_LAT};
    vecs[6] = '{"umax/1",   32'hFFFFFFFF,   32'd1,          1'b0, {32'd0, 32'hFFFFFFFF},      DIV_LAT};
    vecs[7] = '{"u5/9",     32'd5,          32'd9,          1'b0, {32'd5, 32'd0},             DIV_LAT};
    for (int i = 8; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 32'h0000FFFF);
      if (i == 9) rb = rb | 32'h80000000;
      rs = 1'(i & 1);
      vecs[i] = '{$sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs), DIV_LAT};
    end

    // Reset state
    tick();
    tick();
    check("reset ready", 64'(bus.ready_o), 64'd0);
    check("reset result", bus.result_o, 64'd0);
    check("reset stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven transactions, back to back
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i]);
    end

    // annul_i pulsed at BUSY cycle 10 while start_i stays high: the divider
    // drops to IDLE, then re-accepts the new 9/3 operands on the next edge.
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.signed_i  = 1'b0;
    bus.start_i   = 1'b1;
    tick();                              // accept
    for (int i = 0; i < 10; i++) tick();
    bus.annul_i   = 1'b1;
    bus.opdata1_i = 32'd9;
    sb_q.push_back({32'd0, 32'd3});
    tick();                              // abort edge
    bus.annul_i   = 1'b0;
    check("annul ready low", 64'(bus.ready_o), 64'd0);
    wait_ready(n);
    $display("txn annul_9/3 result=%h lat=%0d", bus.result_o, n);
    check("annul restart latency", 64'(n), 64'(DIV_LAT));
    finish_txn("annul_9/3");

    // start_i and annul_i together in IDLE must not accept
    bus.opdata1_i = 32'd8;
    bus.opdata2_i = 32'd2;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("start+annul no ready", 64'(bus.ready_o), 64'd0);
    bus.annul_i = 1'b0;
    sb_q.push_back({32'd0, 32'd4});
    wait_ready(n);
    $display("txn start_annul_8/2 result=%h lat=%0d", bus.result_o, n);
    check("start+annul latency", 64'(n), 64'(DIV_LAT));
    finish_txn("start_annul_8/2");

    // rst mid-BUSY
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    $display("txn rst_busy ready=%0d result=%h", bus.ready_o, bus.result_o);
    check("rst busy ready", 64'(bus.ready_o), 64'd0);
    check("rst busy result", bus.result_o, 64'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // rst in DONE clears a live result
    bus.start_i = 1'b1;
    wait_ready(n);
    check("pre-rst done result", bus.result_o, {32'd0, 32'd10});
    rst = 1'b1;
    tick();
    $display("txn rst_done ready=%0d result=%h", bus.ready_o, bus.result_o);
    check("rst done ready", 64'(bus.ready_o), 64'd0);
    check("rst done result", bus.result_o, 64'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
